// File: rtl/vector_pkg.sv
// vector_pkg: shared widths, FSM state type and byte bit-reversal helper for
// the nibble-to-byte assembler.
package vector_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_LOW,   // waiting for the low nibble of a new byte
        ST_HIGH   // low nibble held, waiting for the high nibble
    } pack_state_t;

    // Bit i moves to bit 7-i.
    function automatic logic [BYTE_W-1:0] bit_rev8(input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] r;
        for (int i = 0; i < BYTE_W; i++) begin
            r[i] = b[BYTE_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/vector_pack_if.sv
// vector_pack_if: nibble input channel and byte output channel of vector_pack.
//   in_nib/in_first/in_rev/in_valid -> block, in_ready <- block
//   out_data/out_par/out_valid <- block, out_ready -> block
// slave  : the assembler side
// master : the source/sink side driving nibbles and consuming bytes
interface vector_pack_if;
    import vector_pkg::*;

    logic [NIB_W-1:0]  in_nib;
    logic              in_first;
    logic              in_rev;
    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] out_data;
    logic              out_par;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_nib, in_first, in_rev, in_valid, out_ready,
        output in_ready, out_data, out_par, out_valid
    );

    modport master (
        output in_nib, in_first, in_rev, in_valid, out_ready,
        input  in_ready, out_data, out_par, out_valid
    );

endinterface

// File: rtl/vector_pack_fifo.sv
// pack_fifo: synchronous FIFO holding {parity, byte} entries.
//   clk, rst_n : clock, async active-low reset (empties the queue)
//   push/wdata : enqueue, ignored when full
//   pop        : dequeue, ignored when empty
//   full/empty : occupancy flags
//   rdata      : entry at the head (raw memory value; caller masks when empty)
// DEPTH must be a power of two so pointers wrap by natural overflow.
module pack_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] rdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vector_pack.sv
// vector_pack: assembles low-then-high nibble pairs into bytes, optionally
// bit-reversed, appends even parity and queues them for a downstream sink.
//   clk, rst_n : clock, async active-low reset
//   bus        : vector_pack_if.slave (nibble input + byte output handshakes)
//   err_cnt    : saturating count of framing errors (orphan high nibble,
//                or a new first nibble arriving while a low nibble is held)
module vector_pack
    import vector_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vector_pack_if.slave         bus,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    pack_state_t       state, nxt;
    logic [NIB_W-1:0]  lo;
    logic              rev;
    logic              xfer, latch, push, err_inc, pop;
    logic              full, empty;
    logic [BYTE_W:0]   head, push_data;
    logic [BYTE_W-1:0] byte_raw, byte_fmt;

    // Readiness depends only on state and FIFO fullness, never on out_ready,
    // so a full FIFO stalls the high nibble even if a pop is coincident.
    assign bus.in_ready = (state == ST_LOW) || !full;
    assign xfer         = bus.in_valid && bus.in_ready;

    assign byte_raw  = {bus.in_nib, lo};
    assign byte_fmt  = rev ? bit_rev8(byte_raw) : byte_raw;
    assign push_data = {^byte_fmt, byte_fmt};

    always_comb begin
        nxt     = state;
        latch   = 1'b0;
        push    = 1'b0;
        err_inc = 1'b0;
        if (xfer) begin
            case (state)
                ST_LOW: begin
                    if (bus.in_first) begin
                        latch = 1'b1;
                        nxt   = ST_HIGH;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (bus.in_first) begin
                        // restart the byte; the held low nibble is lost
                        latch   = 1'b1;
                        err_inc = 1'b1;
                    end else begin
                        push = 1'b1;
                        nxt  = ST_LOW;
                    end
                end
                default: nxt = ST_LOW;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_LOW;
            lo      <= '0;
            rev     <= 1'b0;
            err_cnt <= '0;
        end else begin
            state <= nxt;
            if (latch) begin
                lo  <= bus.in_nib;
                rev <= bus.in_rev;
            end
            if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

    assign pop = !empty && bus.out_ready;

    pack_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BYTE_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .rdata (head)
    );

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : head[BYTE_W-1:0];
    assign bus.out_par   = empty ? 1'b0 : head[BYTE_W];

endmodule

// File: tb/tb_vector_pack.sv
// tb_vector_pack: directed self-checking bench for vector_pack (FIFO_DEPTH=2).
module tb_vector_pack;
    import vector_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] err_cnt;
    int         checks;
    int         failures;

    vector_pack_if bus ();

    vector_pack #(.FIFO_DEPTH(2), .ERR_CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err_cnt (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one nibble and hold it until accepted (bounded wait).
    task automatic send_nib(input logic [3:0] n, input logic f, input logic r);
        int waited;
        waited = 0;
        bus.in_nib   = n;
        bus.in_first = f;
        bus.in_rev   = r;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_nib_timeout observed=in_ready_low expected=accept nib=%0h", n);
        end else begin
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b1;
        bus.in_nib   = '0;
        bus.in_first = 1'b0;
        bus.in_rev   = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;

        // reset asserted between clock edges
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  8'h00);
        chk("rst_out_par",   bus.out_par,   0);
        chk("rst_err_cnt",   err_cnt,       0);
        chk("rst_in_ready",  bus.in_ready,  1);
        chk("rst_state",     dut.state,     ST_LOW);
        #8 rst_n = 1'b1;
        step();

        // basic byte
        send_nib(4'h5, 1'b1, 1'b0);
        send_nib(4'hA, 1'b0, 1'b0);
        chk("basic_valid", bus.out_valid, 1);
        chk("basic_data",  bus.out_data,  8'hA5);
        chk("basic_par",   bus.out_par,   0);
        step();
        chk("basic_one_beat", bus.out_valid, 0);

        // reversal, then confirm it does not persist
        send_nib(4'h1, 1'b1, 1'b1);
        send_nib(4'h0, 1'b0, 1'b0);
        chk("rev_data", bus.out_data, 8'h80);
        chk("rev_par",  bus.out_par,  1);
        send_nib(4'h3, 1'b1, 1'b0);
        send_nib(4'hC, 1'b0, 1'b0);
        chk("norev_data", bus.out_data, 8'hC3);
        chk("norev_par",  bus.out_par,  0);
        step();

        // framing errors
        send_nib(4'h7, 1'b0, 1'b0);
        chk("orphan_err",   err_cnt,       1);
        chk("orphan_noout", bus.out_valid, 0);
        send_nib(4'h3, 1'b1, 1'b0);
        send_nib(4'h4, 1'b1, 1'b0);
        chk("restart_err",   err_cnt,       2);
        chk("restart_noout", bus.out_valid, 0);
        send_nib(4'h6, 1'b0, 1'b0);
        chk("restart_data",  bus.out_data,  8'h64);
        chk("restart_par",   bus.out_par,   1);
        step();
        chk("restart_single", bus.out_valid, 0);
        for (int i = 0; i < 300; i++) send_nib(4'h0, 1'b0, 1'b0);
        chk("err_saturate", err_cnt, 8'hFF);
        chk("err_noout",    bus.out_valid, 0);

        // backpressure: two bytes fill the FIFO, third high nibble stalls
        bus.out_ready = 1'b0;
        send_nib(4'h1, 1'b1, 1'b0);
        send_nib(4'h1, 1'b0, 1'b0);
        send_nib(4'h2, 1'b1, 1'b0);
        send_nib(4'h2, 1'b0, 1'b0);
        send_nib(4'h3, 1'b1, 1'b0);
        chk("bp_in_ready_low", bus.in_ready, 0);
        chk("bp_head",         bus.out_data, 8'h11);
        step();
        chk("bp_head_stable",  bus.out_data, 8'h11);
        bus.in_nib    = 4'h3;
        bus.in_first  = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("bp_stall_with_pop", bus.in_ready, 0);
        step();
        chk("bp_out2",       bus.out_data, 8'h22);
        chk("bp_ready_back", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk("bp_out3",     bus.out_data, 8'h33);
        chk("bp_out3_par", bus.out_par,  0);
        step();
        chk("bp_drained", bus.out_valid, 0);

        // reset mid-operation
        bus.out_ready = 1'b0;
        send_nib(4'hA, 1'b1, 1'b0);
        send_nib(4'h5, 1'b0, 1'b0);
        chk("mid_queued", bus.out_data, 8'h5A);
        send_nib(4'h9, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_data",  bus.out_data,  8'h00);
        chk("mid_rst_err",   err_cnt,       0);
        #1 rst_n = 1'b1;
        step();
        bus.out_ready = 1'b1;
        send_nib(4'h2, 1'b0, 1'b0);
        chk("post_rst_err",   err_cnt,       1);
        chk("post_rst_noout", bus.out_valid, 0);
        chk("post_rst_state", dut.state,     ST_LOW);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vector_pack.md
# vector_pack

Nibble-to-byte assembler: the write-side counterpart to the byte-slicing path that breaks an 8-bit `data` word into a bit, a nibble and reversed-bit vectors. It accepts a stream of 4-bit nibbles (low nibble first, framed by a `first` marker) over a valid/ready handshake. It rebuilds 8-bit bytes, optionally bit-reversed, adds even parity, and queues the result in a small FIFO. Downstream logic consumes the bytes through a second valid/ready handshake.

## Interface
Parameters:
- `FIFO_DEPTH`, default 2: output queue depth in bytes. Must be a power of two and at least 2.
- `ERR_CNT_W`, default 8: width of the framing-error counter.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `in_nib`, in, 4: nibble payload.
- `in_first`, in, 1: marks this nibble as the low nibble of a new byte.
- `in_rev`, in, 1: bit-reverse request, sampled only with the `in_first` nibble.
- `in_valid`, in, 1: source has a nibble.
- `in_ready`, out, 1: block accepts a nibble this cycle.
- `out_data`, out, 8: assembled byte at the FIFO head.
- `out_par`, out, 1: even parity, the XOR of the 8 bits of `out_data`.
- `out_valid`, out, 1: FIFO not empty.
- `out_ready`, in, 1: sink takes the head byte.
- `err_cnt`, out, `ERR_CNT_W`: saturating count of framing errors.

## Operation
- Handshake:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
  - Once `in_valid` is asserted, the source holds it until the transfer completes.
- The FSM has two states, LOW (awaiting the first nibble) and HIGH (low nibble held).
- LOW, transfer with `in_first`=1:
  - Latch `lo <= in_nib` and `rev <= in_rev`.
  - Go to HIGH.
- LOW, transfer with `in_first`=0: discard the nibble, increment `err_cnt`, stay in LOW.
- HIGH, transfer with `in_first`=0:
  - Form `b = {in_nib, lo}`.
  - If `rev`, bit-reverse `b` (bit i moves to bit 7-i).
  - Push `b` and `^b` into the FIFO and go to LOW.
- HIGH, transfer with `in_first`=1:
  - Drop the held low nibble and increment `err_cnt`.
  - Latch the new `lo` and `rev`, and stay in HIGH.
- `in_ready` = (state==LOW) || !fifo_full.
  - `in_ready` never depends on `out_ready` or `in_first`.
  - When the FIFO is full, a HIGH-state nibble therefore stalls, even if a pop happens in the same cycle.
- When `out_valid`=0, `out_data` and `out_par` are 0. Otherwise they show the head entry.
- A pop and a push in the same cycle are legal whenever the FIFO is not full. The occupancy is then unchanged.
- `err_cnt` saturates at all-ones and never wraps.
- Pushes and pops wrap the FIFO pointers modulo `FIFO_DEPTH`. Byte order is strictly preserved.

## Timing
- Reset (asynchronous, effective immediately while `rst_n`=0):
  - State is LOW, the FIFO is empty, `lo` and `rev` are 0.
  - `out_valid`=0, `out_data`=0, `out_par`=0, `err_cnt`=0, `in_ready`=1.
- Reset mid-byte discards the held low nibble and all queued bytes. No error is counted for them.
- Latency: a byte is visible on `out_valid` in the cycle after the clock edge that accepts its high nibble.
- Throughput: one byte per two input cycles when `out_ready` stays high.
- `out_data` is stable while `out_valid && !out_ready`.

## Structure
- Package `vector_pkg` holds:
  - `NIB_W`=4 and `BYTE_W`=8.
  - The state enum `pack_state_t` {`ST_LOW`, `ST_HIGH`}.
  - The function `bit_rev8`.
- Sub-module `pack_fifo`: a synchronous FIFO with parameter `DEPTH` and a 9-bit entry (data plus parity). It has push/pop inputs, full/empty flags and a read-head output.
- Top-level `vector_pack` holds the FSM, the `lo`/`rev` registers, the error counter and the handshake logic.

## Test plan
- Reset:
  - Stimulus: assert `rst_n`=0 asynchronously between clock edges.
  - Required response: `out_valid`=0, `out_data`=0x00, `err_cnt`=0, `in_ready`=1, and the FSM is in LOW.
- Basic byte:
  - Stimulus: nibble 0x5 with `first`=1, then 0xA with `first`=0, with `out_ready`=1.
  - Required response: one cycle later, `out_data`=0xA5 and `out_par`=0, for one beat.
- Reversal:
  - Stimulus: nibble 0x1 with `first`=1 and `rev`=1, then 0x0.
  - Required response: `out_data`=0x80 and `out_par`=1.
  - Stimulus: the next byte, 0x3 with `first`=1 and `rev`=0, then 0xC.
  - Required response: `out_data`=0xC3 (reversal does not persist).
- Framing errors:
  - Stimulus: orphan 0x7 (`first`=0) in LOW.
  - Required response: `err_cnt`=1 and no output.
  - Stimulus: then 0x3 (`first`), 0x4 (`first`), 0x6.
  - Required response: `err_cnt`=2 and a single output, 0x64.
  - Stimulus: force 300 errors.
  - Required response: `err_cnt`=255.
- Backpressure (`FIFO_DEPTH`=2):
  - Stimulus: hold `out_ready`=0 and send bytes 0x11, 0x22, 0x33.
  - Required response: `in_ready`=0 while in HIGH with the third high nibble pending.
  - Stimulus: release `out_ready`.
  - Required response: outputs 0x11, 0x22, 0x33 in order, none lost or duplicated.
- Reset mid-operation:
  - Stimulus: queue 0x5A, send low nibble 0x9 (`first`), then pulse `rst_n`.
  - Required response: the FIFO is empty and `out_valid`=0.
  - Stimulus: a following 0x2 with `first`=0.
  - Required response: `err_cnt`=1 and no output.
